// File: rtl/weight_stream_pkg.sv
// Shared widths, FSM state encoding and the FIFO entry layout for the
// weight SRAM stream reader.
package weight_stream_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 18;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/wsram_sync_fifo.sv
// Small synchronous FIFO with an occupancy count and a flush.
// It has no full/empty back-pressure; the writer must never overflow it.
module wsram_sync_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately left unreset; count_q alone says which entries are live.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem[rd_ptr_q];
  assign count_o = count_q;

  overflow_a : assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !pop_i && !flush_i && count_q == CNT_W'(DEPTH)));

endmodule

// File: rtl/weight_sram_stream_reader.sv
// Burst reader for the weight SRAM: issues sequential reads under a credit
// limit and streams the returned words out through a small FIFO.
module weight_sram_stream_reader
  import weight_stream_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_a,
  input  logic [DATA_W-1:0] sram_do,
  output logic              w_valid,
  output logic [DATA_W-1:0] w_data,
  output logic              w_last,
  input  logic              w_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W:0] LEN_ONE = 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   issued_q, issued_d;
  logic [ADDR_W:0]   popped_q, popped_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;

  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    pending;
  fifo_entry_t       head, push_entry;
  logic              pop, issue, last_issue, last_pop, flush;

  // Credit: words buffered plus the read in flight, counting this cycle's pop as already gone.
  assign pop        = w_valid & w_ready;
  assign pending    = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
  assign issue      = (state_q == ISSUE) && !abort && (pending < (CNT_W+1)'(FIFO_DEPTH));
  assign last_issue = issue && (issued_q == len_q - LEN_ONE);
  assign last_pop   = pop && (popped_q == len_q - LEN_ONE);
  assign flush      = abort && ((state_q == ISSUE) || (state_q == DRAIN));
  assign push_entry = '{last: inflight_last_q, data: sram_do};

  wsram_sync_fifo #(
    .WIDTH($bits(fifo_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .push_i     (inflight_q),
    .push_data_i(push_entry),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (fifo_count)
  );

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (len != '0) ? ISSUE : DONE;
      ISSUE:   if (abort) state_d = IDLE;
               else if (last_issue) state_d = DRAIN;
      DRAIN:   if (abort) state_d = IDLE;
               else if (last_pop) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == ISSUE) || (state_q == DRAIN);
    done     = (state_q == DONE);
    sram_oe  = busy;
    sram_cs  = issue;
    sram_a   = addr_q;
    sram_web = 1'b1;
    w_valid  = (fifo_count != '0);
    w_data   = w_valid ? head.data : '0;
    w_last   = w_valid & head.last;
  end

  always_comb begin
    addr_d          = addr_q;
    len_d           = len_q;
    issued_d        = issued_q;
    popped_d        = popped_q;
    inflight_d      = issue;
    inflight_last_d = last_issue;
    if (state_q == IDLE && start) begin
      addr_d   = base_addr;
      len_d    = len;
      issued_d = '0;
      popped_d = '0;
    end else begin
      if (issue) begin
        addr_d   = addr_q + ADDR_W'(1);
        issued_d = issued_q + LEN_ONE;
      end
      if (pop) popped_d = popped_q + LEN_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      popped_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      addr_q          <= addr_d;
      len_q           <= len_d;
      issued_q        <= issued_d;
      popped_q        <= popped_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

endmodule

// File: tb/tb_weight_sram_stream_reader.sv
// Scoreboard bench: each burst pushes its expected addresses and words from a
// memory image; a negedge monitor pops and compares whatever the DUT presents.
module tb_weight_sram_stream_reader;
  import weight_stream_pkg::*;

  localparam int DEPTH = 4;
  localparam int WORDS = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              w_ready = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   len = '0;
  logic [DATA_W-1:0] sram_do = '0;
  logic              busy, done, sram_cs, sram_oe, sram_web, w_valid, w_last;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] w_data;

  logic [DATA_W-1:0] mem [WORDS];
  logic [DATA_W:0]   exp_words [$];
  int                exp_addrs [$];

  int checks = 0, failures = 0;
  int cyc = 0, done_seen = 0, exp_dones = 0, xfers = 0, reads = 0, outstanding = 0;
  int last_xfer_cyc = 0;
  bit last_xfer_pending = 0, prev_stall = 0, prev_abort = 0;
  logic [DATA_W-1:0] prev_data = '0;
  logic              prev_last = 1'b0;
  logic [31:0]       mon_exp;

  weight_sram_stream_reader #(.FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .base_addr(base_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .sram_cs  (sram_cs),
    .sram_oe  (sram_oe),
    .sram_web (sram_web),
    .sram_a   (sram_a),
    .sram_do  (sram_do),
    .w_valid  (w_valid),
    .w_data   (w_data),
    .w_last   (w_last),
    .w_ready  (w_ready)
  );

  always #5 clk = ~clk;

  // SRAM macro: data appears the cycle after the issuing edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sram_cs) sram_do <= mem[sram_a];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_words.delete();
      exp_addrs.delete();
      outstanding = 0;
      prev_stall = 0;
      prev_abort = 0;
      last_xfer_pending = 0;
    end else begin
      if (prev_stall && !prev_abort) begin
        check("stall_valid", w_valid, 1);
        check("stall_data", w_data, prev_data);
        check("stall_last", w_last, prev_last);
      end
      if (sram_cs) begin
        reads++;
        outstanding++;
        mon_exp = 32'hDEAD_BEEF;
        if (exp_addrs.size() != 0) mon_exp = 32'(exp_addrs.pop_front());
        check("read_addr", sram_a, mon_exp);
      end
      if (w_valid && w_ready) begin
        xfers++;
        outstanding--;
        mon_exp = 32'hFFFF_FFFF;
        if (exp_words.size() != 0) mon_exp = 32'(exp_words.pop_front());
        check("word_last_data", {w_last, w_data}, mon_exp);
        if (w_last) begin
          last_xfer_cyc = cyc;
          last_xfer_pending = 1;
        end
      end
      if (sram_cs) check("credit_bound", outstanding <= DEPTH, 1);
      if (done) begin
        done_seen++;
        check("done_expected", done_seen <= exp_dones, 1);
        check("done_queue_empty", exp_words.size(), 0);
        if (last_xfer_pending) check("done_latency", cyc - last_xfer_cyc, 1);
        last_xfer_pending = 0;
      end
      prev_stall = w_valid && !w_ready;
      prev_data  = w_data;
      prev_last  = w_last;
      prev_abort = abort;
      if (abort && busy) begin
        exp_words.delete();
        exp_addrs.delete();
        outstanding = 0;
        last_xfer_pending = 0;
      end
    end
  end

  task automatic do_start(input int base, input int n, input bit expect_done);
    int a;
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = ADDR_W'(base);
    len = (ADDR_W+1)'(n);
    for (int i = 0; i < n; i++) begin
      a = (base + i) % WORDS;
      exp_addrs.push_back(a);
      exp_words.push_back({(i == n - 1), mem[a]});
    end
    if (expect_done) exp_dones++;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rnd, input int budget);
    int d0 = done_seen;
    bit got = 0;
    for (int i = 0; i < budget; i++) begin
      if (rnd) w_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (done_seen != d0) begin
        got = 1;
        break;
      end
    end
    w_ready = 1'b1;
    check("done_arrived", got, 1);
  endtask

  task automatic wait_xfers(input int x0, input int n, input int budget);
    bit got = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (xfers - x0 >= n) begin
        got = 1;
        break;
      end
    end
    check("xfers_arrived", got, 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_cs"}, sram_cs, 0);
    check({tag, "_oe"}, sram_oe, 0);
    check({tag, "_web"}, sram_web, 1);
    check({tag, "_a"}, sram_a, 0);
    check({tag, "_valid"}, w_valid, 0);
    check({tag, "_data"}, w_data, 0);
    check({tag, "_last"}, w_last, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, x0;
    for (int i = 0; i < WORDS; i++) mem[i] = DATA_W'($urandom);

    #12;
    check_reset("rst");
    rst_n = 1'b1;
    w_ready = 1'b1;

    // 1: base 0, len 8, full throughput and first-word latency.
    do_start(0, 8, 1);
    check("t1_busy", busy, 1);
    for (int i = 0; i < 8; i++) begin
      check("t1_cs", sram_cs, 1);
      check("t1_valid", w_valid, (i >= 2));
      @(posedge clk); #1;
    end
    check("t1_cs_after", sram_cs, 0);
    wait_done(0, 100);

    // 2: address wrap.
    do_start(16382, 4, 1);
    wait_done(0, 100);

    // 3: random back-pressure.
    do_start($urandom_range(0, WORDS - 1), 16, 1);
    wait_done(1, 400);

    // 4: downstream blocked from the start; only the credit's worth is issued.
    w_ready = 1'b0;
    do_start($urandom_range(0, WORDS - 1), 10, 1);
    r0 = reads;
    repeat (12) begin
      @(posedge clk); #1;
    end
    check("t4_reads", reads - r0, 4);
    check("t4_cs_idle", sram_cs, 0);
    check("t4_valid", w_valid, 1);
    w_ready = 1'b1;
    wait_done(0, 100);

    // 5: zero-length burst.
    do_start(5, 0, 1);
    check("t5_done", done, 1);
    check("t5_cs", sram_cs, 0);
    check("t5_busy", busy, 0);
    @(posedge clk); #1;
    check("t5_done_drop", done, 0);
    check("t5_valid", w_valid, 0);

    // 6a: abort after five words, then a fresh burst.
    x0 = xfers;
    do_start($urandom_range(0, WORDS - 1), 12, 0);
    wait_xfers(x0, 5, 100);
    abort = 1'b1;
    w_ready = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    check("t6_valid", w_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_cs", sram_cs, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("t6_no_done", done_seen, exp_dones);
    w_ready = 1'b1;
    do_start(100, 3, 1);
    wait_done(0, 100);

    // 6b: reset in the middle of a burst.
    x0 = xfers;
    do_start($urandom_range(0, WORDS - 1), 12, 0);
    wait_xfers(x0, 3, 100);
    rst_n = 1'b0;
    w_ready = 1'b0;
    #1;
    check_reset("mrst");
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset("mrst_post");
    w_ready = 1'b1;
    do_start($urandom_range(0, WORDS - 1), 6, 1);
    wait_done(0, 100);

    // Random bursts with random back-pressure.
    repeat (4) begin
      do_start($urandom_range(0, WORDS - 1), $urandom_range(1, 24), 1);
      wait_done(1, 600);
    end

    repeat (3) @(posedge clk);
    #1;
    check("final_done_count", done_seen, exp_dones);
    check("final_words_left", exp_words.size(), 0);
    check("final_addrs_left", exp_addrs.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
